// File: rtl/csr_bank_param.sv
// Parametrised CSR slave on the Sir register bus: NUM_REG 32-bit registers, each RW,
// self-clearing pulse or sticky W1C status. Two-stage pipeline gives an ack two cycles after SirSel.
module csr_bank_param #(
   parameter int                    SLAVE_SIZE  = 16,
   parameter logic [SLAVE_SIZE-1:0] BASE_ADDR   = 16'h3000,
   parameter int                    NUM_REG     = 8,
   parameter logic [NUM_REG-1:0]    PULSE_MASK  = '0,
   parameter logic [NUM_REG-1:0]    STICKY_MASK = '0,
   parameter logic [31:0]           INIT_VALUE  = 32'h0,
   parameter int                    PULSE_LEN   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SLAVE_SIZE-1:0]   SirAddr,
   input  logic                    SirRead,
   input  logic [31:0]             SirWdat,
   input  logic                    SirSel,
   output logic                    SirDack,
   output logic [31:0]             SirRdat,
   output logic [32*NUM_REG-1:0]   ctrl_q,
   output logic [NUM_REG-1:0]      pulse_out,
   input  logic [32*NUM_REG-1:0]   sts_in,
   output logic                    irq
);

   localparam int          IDX_W  = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
   localparam logic [31:0] BASE32 = 32'(BASE_ADDR);
   localparam logic [31:0] TOP32  = BASE32 + 32'(4 * NUM_REG);

   logic [31:0]        regs [NUM_REG];
   logic [7:0]         cnt  [NUM_REG];
   logic [31:0]        view [NUM_REG];
   logic [31:0]        addr32;
   logic               hit;
   logic [IDX_W-1:0]   idx;
   logic [NUM_REG-1:0] wr_en;
   logic [31:0]        rd_val;
   logic               sticky_any;
   logic               s1_hit;
   logic               s1_read;
   logic [31:0]        s1_rdat;

   assign addr32 = 32'(SirAddr);
   assign hit    = SirSel && (SirAddr[1:0] == 2'b00) && (addr32 >= BASE32) && (addr32 < TOP32);
   assign idx    = IDX_W'((addr32 - BASE32) >> 2);

   // PULSE wins over STICKY when both mask bits are set.
   always_comb begin
      wr_en      = '0;
      rd_val     = '0;
      sticky_any = 1'b0;
      for (int i = 0; i < NUM_REG; i++) begin
         pulse_out[i] = PULSE_MASK[i] && (cnt[i] != 8'd0);
         view[i]      = PULSE_MASK[i] ? {regs[i][31:1], pulse_out[i]} : regs[i];
         wr_en[i]     = hit && !SirRead && (idx == IDX_W'(i));
         if (idx == IDX_W'(i))
            rd_val = view[i];
         if (STICKY_MASK[i] && !PULSE_MASK[i])
            sticky_any = sticky_any | (|regs[i]);
      end
   end

   for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_ctrl
      assign ctrl_q[32*gi +: 32] = view[gi];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            regs[i] <= (PULSE_MASK[i] || STICKY_MASK[i]) ? 32'h0 : INIT_VALUE;
            cnt[i]  <= 8'd0;
         end
         s1_hit  <= 1'b0;
         s1_read <= 1'b0;
         s1_rdat <= '0;
         SirDack <= 1'b0;
         SirRdat <= '0;
         irq     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REG; i++) begin
            if (PULSE_MASK[i]) begin
               if (wr_en[i])
                  regs[i] <= {SirWdat[31:1], 1'b0};
               if (wr_en[i] && SirWdat[0])
                  cnt[i] <= 8'(PULSE_LEN);
               else if (cnt[i] != 8'd0)
                  cnt[i] <= cnt[i] - 8'd1;
            end else if (STICKY_MASK[i]) begin
               // set wins: sts_in is ORed in after the clear
               regs[i] <= (regs[i] & ~(wr_en[i] ? SirWdat : 32'h0)) | sts_in[32*i +: 32];
            end else if (wr_en[i]) begin
               regs[i] <= SirWdat;
            end
         end
         s1_hit  <= hit;
         s1_read <= SirRead;
         s1_rdat <= rd_val;
         SirDack <= s1_hit;
         SirRdat <= (s1_hit && s1_read) ? s1_rdat : 32'h0;
         irq     <= sticky_any;
      end
   end

endmodule

// File: tb/tb_csr_bank_param.sv
// Directed bench for csr_bank_param: reg1 is PULSE, reg2 is STICKY, the rest RW with
// reset value 32'hA5. Expected values are hand-computed constants.
module tb_csr_bank_param;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   SirAddr;
   logic          SirRead;
   logic [31:0]   SirWdat;
   logic          SirSel;
   logic          SirDack;
   logic [31:0]   SirRdat;
   logic [255:0]  ctrl_q;
   logic [7:0]    pulse_out;
   logic [255:0]  sts_in;
   logic          irq;

   int vectors     = 0;
   int miscompares = 0;

   csr_bank_param #(
      .SLAVE_SIZE (16),
      .BASE_ADDR  (16'h3000),
      .NUM_REG    (8),
      .PULSE_MASK (8'h02),
      .STICKY_MASK(8'h04),
      .INIT_VALUE (32'hA5),
      .PULSE_LEN  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .SirAddr  (SirAddr),
      .SirRead  (SirRead),
      .SirWdat  (SirWdat),
      .SirSel   (SirSel),
      .SirDack  (SirDack),
      .SirRdat  (SirRdat),
      .ctrl_q   (ctrl_q),
      .pulse_out(pulse_out),
      .sts_in   (sts_in),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One access: SirSel high for one cycle; returns ack at T+1, ack/rdat at T+2, ack at T+3.
   task automatic bus(input logic [15:0] a, input logic rd, input logic [31:0] wd,
                      output logic ack1, output logic ack2, output logic [31:0] rdat2,
                      output logic ack3);
      SirAddr = a; SirRead = rd; SirWdat = wd; SirSel = 1'b1;
      cyc();
      SirSel = 1'b0;
      ack1 = SirDack;
      cyc();
      ack2 = SirDack; rdat2 = SirRdat;
      cyc();
      ack3 = SirDack;
   endtask

   logic        a1, a2, a3;
   logic [31:0] rd2;
   logic [9:1]  hist;
   logic [5:0]  ack_seq;
   logic [31:0] rd_seq [6];

   initial begin
      rst = 1'b1; SirAddr = '0; SirRead = 1'b0; SirWdat = '0; SirSel = 1'b0; sts_in = '0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();

      // reset state
      chk("rst_reg0",   ctrl_q[0 +: 32],  32'hA5);
      chk("rst_reg3",   ctrl_q[96 +: 32], 32'hA5);
      chk("rst_reg7",   ctrl_q[224 +: 32], 32'hA5);
      chk("rst_reg1",   ctrl_q[32 +: 32], 32'h0);
      chk("rst_reg2",   ctrl_q[64 +: 32], 32'h0);
      chk("rst_dack",   32'(SirDack), 32'h0);
      chk("rst_rdat",   SirRdat, 32'h0);
      chk("rst_pulse",  32'(pulse_out), 32'h0);
      chk("rst_irq",    32'(irq), 32'h0);

      // RW write then read
      bus(16'h300C, 1'b0, 32'h1234, a1, a2, rd2, a3);
      chk("wr_ack_t1",  32'(a1), 32'h0);
      chk("wr_ack_t2",  32'(a2), 32'h1);
      chk("wr_rdat",    rd2, 32'h0);
      chk("wr_ack_t3",  32'(a3), 32'h0);
      chk("wr_ctrl",    ctrl_q[96 +: 32], 32'h1234);
      bus(16'h300C, 1'b1, 32'h0, a1, a2, rd2, a3);
      chk("rd_ack_t1",  32'(a1), 32'h0);
      chk("rd_ack_t2",  32'(a2), 32'h1);
      chk("rd_rdat",    rd2, 32'h1234);
      chk("rd_ack_t3",  32'(a3), 32'h0);
      bus(16'h301C, 1'b0, 32'h77, a1, a2, rd2, a3);
      chk("last_ack",   32'(a2), 32'h1);
      chk("last_ctrl",  ctrl_q[224 +: 32], 32'h77);

      // single pulse: high for exactly 4 cycles
      SirAddr = 16'h3004; SirRead = 1'b0; SirWdat = 32'h1; SirSel = 1'b1;
      cyc();
      chk("pulse_ctrl_bit0", 32'(ctrl_q[32]), 32'h1);
      for (int k = 1; k <= 9; k++) begin
         hist[k] = pulse_out[1];
         SirSel = 1'b0;
         cyc();
      end
      chk("pulse_single", 32'(hist), 32'h00F);

      bus(16'h3004, 1'b0, 32'hF0, a1, a2, rd2, a3);
      chk("pulse_bit0_zero", 32'(pulse_out), 32'h0);
      bus(16'h3004, 1'b1, 32'h0, a1, a2, rd2, a3);
      chk("pulse_rd_stored", rd2, 32'hF0);

      // reload at pulse cycle 2 -> 6 contiguous cycles
      SirAddr = 16'h3004; SirRead = 1'b0; SirWdat = 32'h11; SirSel = 1'b1;
      cyc();
      for (int k = 1; k <= 9; k++) begin
         hist[k] = pulse_out[1];
         SirSel = (k == 2);
         cyc();
      end
      chk("pulse_extend", 32'(hist), 32'h03F);

      // sticky set / read / W1C / set-wins
      sts_in[64 +: 32] = 32'h10;
      cyc();
      sts_in = '0;
      chk("sticky_set",  ctrl_q[64 +: 32], 32'h10);
      chk("irq_lag",     32'(irq), 32'h0);
      cyc();
      chk("irq_set",     32'(irq), 32'h1);
      bus(16'h3008, 1'b1, 32'h0, a1, a2, rd2, a3);
      chk("sticky_rd",   rd2, 32'h10);
      chk("irq_after_rd", 32'(irq), 32'h1);
      bus(16'h3008, 1'b0, 32'h10, a1, a2, rd2, a3);
      chk("sticky_clr",  ctrl_q[64 +: 32], 32'h0);
      chk("irq_clr",     32'(irq), 32'h0);
      bus(16'h3008, 1'b1, 32'h0, a1, a2, rd2, a3);
      chk("sticky_rd0",  rd2, 32'h0);
      SirAddr = 16'h3008; SirRead = 1'b0; SirWdat = 32'h10; SirSel = 1'b1;
      sts_in[64 +: 32] = 32'h10;
      cyc();
      SirSel = 1'b0; sts_in = '0;
      chk("sticky_set_wins", ctrl_q[64 +: 32], 32'h10);
      cyc(); cyc();

      // back-to-back: two hits then a miss below the base
      for (int k = 0; k < 6; k++) begin
         SirRead = 1'b1;
         SirSel  = (k < 3);
         SirAddr = (k == 0) ? 16'h3000 : (k == 1) ? 16'h3004 : 16'h2FFC;
         ack_seq[k] = SirDack;
         rd_seq[k]  = SirRdat;
         cyc();
      end
      chk("b2b_acks",  32'(ack_seq), 32'h0C);
      chk("b2b_rd0",   rd_seq[2], 32'hA5);
      chk("b2b_rd1",   rd_seq[3], 32'h10);

      // unaligned and out-of-range writes must be ignored
      bus(16'h3002, 1'b0, 32'hDEAD, a1, a2, rd2, a3);
      chk("miss_unal_ack", 32'({a1, a2, a3}), 32'h0);
      bus(16'h3020, 1'b0, 32'hBEEF, a1, a2, rd2, a3);
      chk("miss_top_ack",  32'({a1, a2, a3}), 32'h0);
      chk("miss_reg0",     ctrl_q[0 +: 32], 32'hA5);

      // reset one cycle after a read's SirSel
      SirAddr = 16'h300C; SirRead = 1'b1; SirSel = 1'b1;
      cyc();
      SirSel = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_mid_dack",  32'(SirDack), 32'h0);
      chk("rst_mid_rdat",  SirRdat, 32'h0);
      chk("rst_mid_reg3",  ctrl_q[96 +: 32], 32'hA5);
      chk("rst_mid_reg7",  ctrl_q[224 +: 32], 32'hA5);
      chk("rst_mid_sticky", ctrl_q[64 +: 32], 32'h0);
      chk("rst_mid_irq",   32'(irq), 32'h0);
      cyc();
      chk("rst_mid_dack2", 32'(SirDack), 32'h0);

      // reset aborts an active pulse
      SirAddr = 16'h3004; SirRead = 1'b0; SirWdat = 32'h1; SirSel = 1'b1;
      cyc();
      chk("abort_pre",  32'(pulse_out[1]), 32'h1);
      SirSel = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("abort_post", 32'(pulse_out), 32'h0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
